// File: rtl/cp0_intr.sv
// rtl/cp0_intr.sv - MIPS coprocessor-0 registers, timer and interrupt trap sequencer
module cp0_intr #(
    parameter logic [31:0] HANDLER_ADDR = 32'hC000_0180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        mtc0,
    input  logic        mfc0,
    input  logic        eret,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [31:0] pc_e,
    input  logic        uart_rx_valid,
    input  logic        uart_tx_ready,
    output logic [31:0] cp0_rdata,
    output logic        trap,
    output logic [31:0] trap_pc,
    output logic [31:0] epc
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] TRAP    = 2'd1;
    localparam logic [1:0] HANDLER = 2'd2;

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    logic [1:0]  state;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] epcReg;
    logic [7:0]  statusIm;
    logic        statusIe;
    logic        ip7;

    logic [7:0]  ipVec;
    logic        pending;
    logic        takeTrap;
    logic        eretTake;
    logic        wrEn;
    logic        wrCount;
    logic        wrCompare;
    logic        wrStatus;
    logic        wrEpc;
    logic        timerMatch;
    logic [31:0] rdata;

    // IP bits 15:8 of Cause: IP7 timer, IP3 tx ready, IP2 rx valid
    assign ipVec    = {ip7, 3'b000, uart_tx_ready, uart_rx_valid, 2'b00};
    assign pending  = statusIe & (|(ipVec & statusIm));
    assign takeTrap = (state == RUN) & pending & ~stall & ~eret;
    assign eretTake = (state == HANDLER) & eret & ~stall;

    // The instruction in E is flushed when a trap is decided or in flight,
    // so its mtc0 must not commit
    assign wrEn      = mtc0 & ~stall & (state != TRAP) & ~takeTrap;
    assign wrCount   = wrEn & (cp0_addr == ADDR_COUNT);
    assign wrCompare = wrEn & (cp0_addr == ADDR_COMPARE);
    assign wrStatus  = wrEn & (cp0_addr == ADDR_STATUS);
    assign wrEpc     = wrEn & (cp0_addr == ADDR_EPC);

    // A software write to either timer register masks that cycle's compare
    assign timerMatch = (count == compare) & ~wrCount & ~wrCompare;

    // Trap sequencer: RUN -> TRAP (one cycle) -> HANDLER -> RUN on eret
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (takeTrap) state <= TRAP;
                TRAP:    state <= HANDLER;
                HANDLER: if (eretTake) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Free-running Count; a write replaces the increment
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (wrCount) begin
            count <= cp0_wdata;
        end else begin
            count <= count + 32'd1;
        end
    end

    // Compare register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            compare <= '0;
        end else if (wrCompare) begin
            compare <= cp0_wdata;
        end
    end

    // Sticky timer interrupt, cleared by writing Compare
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ip7 <= 1'b0;
        end else if (wrCompare) begin
            ip7 <= 1'b0;
        end else if (timerMatch) begin
            ip7 <= 1'b1;
        end
    end

    // Status IM/IE; trap entry clears IE, eret sets it and wins over a write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            statusIm <= '0;
            statusIe <= 1'b0;
        end else begin
            if (wrStatus) begin
                statusIm <= cp0_wdata[15:8];
                statusIe <= cp0_wdata[0];
            end
            if (state == TRAP) begin
                statusIe <= 1'b0;
            end else if (eretTake) begin
                statusIe <= 1'b1;
            end
        end
    end

    // EPC captures the restart PC of the instruction flushed by the trap
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            epcReg <= '0;
        end else if (state == TRAP) begin
            epcReg <= pc_e;
        end else if (wrEpc) begin
            epcReg <= cp0_wdata;
        end
    end

    // Same-cycle mfc0 read mux; Count returns its pre-increment value
    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (cp0_addr)
                ADDR_COUNT:   rdata = count;
                ADDR_COMPARE: rdata = compare;
                ADDR_STATUS:  rdata = {16'h0000, statusIm, 7'b0000000, statusIe};
                ADDR_CAUSE:   rdata = {16'h0000, ipVec, 8'h00};
                ADDR_EPC:     rdata = epcReg;
                default:      rdata = '0;
            endcase
        end
    end

    assign cp0_rdata = rdata;
    assign trap      = (state == TRAP);
    assign trap_pc   = HANDLER_ADDR;
    assign epc       = epcReg;

endmodule

// File: tb/tb_cp0_intr.sv
// tb/tb_cp0_intr.sv - self-checking bench for cp0_intr: vector table, corner sequences, random vs model
module tb_cp0_intr;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        mtc0;
    logic        mfc0;
    logic        eret;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] pc_e;
    logic        uart_rx_valid;
    logic        uart_tx_ready;
    logic [31:0] cp0_rdata;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] epc;

    cp0_intr dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .mtc0          (mtc0),
        .mfc0          (mfc0),
        .eret          (eret),
        .cp0_addr      (cp0_addr),
        .cp0_wdata     (cp0_wdata),
        .pc_e          (pc_e),
        .uart_rx_valid (uart_rx_valid),
        .uart_tx_ready (uart_tx_ready),
        .cp0_rdata     (cp0_rdata),
        .trap          (trap),
        .trap_pc       (trap_pc),
        .epc           (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural view of the CP0 registers
    localparam int M_RUN = 0, M_TRAP = 1, M_HANDLER = 2;
    int          mMode = M_RUN;
    logic [31:0] mCount = 0, mCompare = 0, mEpc = 0;
    logic [7:0]  mIm = 0;
    logic        mIe = 0, mIp7 = 0;

    logic [31:0] sampledRdata;
    logic        sampledTrap;
    logic [31:0] sampledEpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] modelIp(input logic rx, input logic tx);
        logic [7:0] ip;
        ip = 8'h00;
        ip[7] = mIp7;
        ip[3] = tx;
        ip[2] = rx;
        return ip;
    endfunction

    function automatic logic modelPending(input logic rx, input logic tx);
        return mIe && ((modelIp(rx, tx) & mIm) != 8'h00);
    endfunction

    function automatic logic [31:0] modelRead(input logic rd, input logic [4:0] a, input logic rx, input logic tx);
        if (!rd) return 32'h0;
        case (a)
            5'd9:    return mCount;
            5'd11:   return mCompare;
            5'd12:   return {16'h0, mIm, 8'h00} | {31'h0, mIe};
            5'd13:   return {16'h0, modelIp(rx, tx), 8'h00};
            5'd14:   return mEpc;
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: drive, check read, advance model at the edge, check registered outputs
    task automatic step(input logic iMtc0, input logic iMfc0, input logic iEret, input logic iStall,
                        input logic [4:0] iAddr, input logic [31:0] iWdata, input logic [31:0] iPc,
                        input logic iRx, input logic iTx, input logic iRst);
        logic goTrap, commit, hit;
        mtc0 = iMtc0; mfc0 = iMfc0; eret = iEret; stall = iStall;
        cp0_addr = iAddr; cp0_wdata = iWdata; pc_e = iPc;
        uart_rx_valid = iRx; uart_tx_ready = iTx; reset_n = iRst;
        #1;
        sampledRdata = cp0_rdata;
        check("rdata", cp0_rdata, modelRead(iMfc0, iAddr, iRx, iTx));
        @(posedge clk);
        if (!iRst) begin
            mMode = M_RUN; mCount = 0; mCompare = 0; mEpc = 0; mIm = 0; mIe = 0; mIp7 = 0;
        end else begin
            goTrap = (mMode == M_RUN) && modelPending(iRx, iTx) && !iStall && !iEret;
            commit = iMtc0 && !iStall && (mMode != M_TRAP) && !goTrap;
            hit = (mCount == mCompare) && !(commit && (iAddr == 5'd9 || iAddr == 5'd11));
            mCount = (commit && iAddr == 5'd9) ? iWdata : mCount + 1;
            if (commit && iAddr == 5'd11) begin
                mCompare = iWdata; mIp7 = 0;
            end else if (hit) begin
                mIp7 = 1;
            end
            if (commit && iAddr == 5'd12) begin
                mIm = iWdata[15:8]; mIe = iWdata[0];
            end
            if (commit && iAddr == 5'd14) mEpc = iWdata;
            if (mMode == M_TRAP) begin
                mEpc = iPc; mIe = 0; mMode = M_HANDLER;
            end else if (mMode == M_HANDLER && iEret && !iStall) begin
                mIe = 1; mMode = M_RUN;
            end else if (goTrap) begin
                mMode = M_TRAP;
            end
        end
        #1;
        sampledTrap = trap;
        sampledEpc = epc;
        check("trap", {31'h0, trap}, {31'h0, mMode == M_TRAP});
        check("epc", epc, mEpc);
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, input logic rx, input logic tx);
        step(0, 1, 0, 0, a, 32'h0, 32'h0, rx, tx, 1);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic rx, input logic tx);
        step(1, 0, 0, 0, a, d, 32'h0, rx, tx, 1);
    endtask

    typedef struct {
        logic        mtc0;
        logic        mfc0;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        rx;
        logic        tx;
        logic [31:0] expRdata;
        logic        expTrap;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic r, input logic [4:0] a, input logic [31:0] d,
                                input logic rx, input logic tx, input logic [31:0] er);
        vec_t v;
        v.mtc0 = w; v.mfc0 = r; v.addr = a; v.wdata = d; v.rx = rx; v.tx = tx;
        v.expRdata = er; v.expTrap = 1'b0;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        logic [31:0] c0;
        int firstIp, firstTrap, pulses;
        logic rRx, rTx;

        // Vectors start on the first cycle out of reset (Count == Compare == 0 there)
        vecs[0]  = mk(0, 1, 5'd13, 32'h0,         0, 0, 32'h0000_0000);
        vecs[1]  = mk(0, 1, 5'd11, 32'h0,         0, 0, 32'h0000_0000);
        vecs[2]  = mk(0, 1, 5'd13, 32'h0,         0, 0, 32'h0000_8000);
        vecs[3]  = mk(1, 0, 5'd11, 32'hFFFF_0000, 0, 0, 32'h0000_0000);
        vecs[4]  = mk(0, 1, 5'd13, 32'h0,         0, 0, 32'h0000_0000);
        vecs[5]  = mk(0, 1, 5'd11, 32'h0,         0, 0, 32'hFFFF_0000);
        vecs[6]  = mk(0, 1, 5'd12, 32'h0,         0, 0, 32'h0000_0000);
        vecs[7]  = mk(0, 1, 5'd14, 32'h0,         0, 0, 32'h0000_0000);
        vecs[8]  = mk(0, 1, 5'd7,  32'h0,         0, 0, 32'h0000_0000);
        vecs[9]  = mk(1, 0, 5'd7,  32'hFFFF_FFFF, 0, 0, 32'h0000_0000);
        vecs[10] = mk(0, 1, 5'd7,  32'h0,         0, 0, 32'h0000_0000);
        vecs[11] = mk(1, 0, 5'd12, 32'hFFFF_FF00, 0, 0, 32'h0000_0000);
        vecs[12] = mk(0, 1, 5'd12, 32'h0,         0, 0, 32'h0000_FF00);
        vecs[13] = mk(0, 1, 5'd13, 32'h0,         1, 1, 32'h0000_0C00);
        vecs[14] = mk(0, 0, 5'd12, 32'h0,         1, 1, 32'h0000_0000);

        @(negedge clk);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0);
        check("trap_pc", trap_pc, 32'hC000_0180);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].mtc0, vecs[i].mfc0, 0, 0, vecs[i].addr, vecs[i].wdata, 32'h0,
                 vecs[i].rx, vecs[i].tx, 1);
            check($sformatf("vec%0d_rdata", i), sampledRdata, vecs[i].expRdata);
            check($sformatf("vec%0d_trap", i), {31'h0, sampledTrap}, {31'h0, vecs[i].expTrap});
        end

        // Count advances by one per cycle
        rd(5'd9, 0, 0);
        c0 = sampledRdata;
        check("count_small", {31'h0, c0 < 32'd64}, 32'h1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 1);
        rd(5'd9, 0, 0);
        check("count_delta10", sampledRdata - c0, 32'd10);

        // Timer interrupt: Compare=20, Status=0x8001, Count=0
        wr(5'd11, 32'd20, 0, 0);
        wr(5'd12, 32'h0000_8001, 0, 0);
        wr(5'd9, 32'd0, 0, 0);
        firstIp = -1; firstTrap = -1; pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            step(0, 1, 0, 0, 5'd13, 32'h0, 32'h0040_0000 + k * 4, 0, 0, 1);
            if (firstIp < 0 && sampledRdata[15]) firstIp = k;
            if (sampledTrap) begin
                pulses++;
                if (firstTrap < 0) firstTrap = k;
            end
        end
        check("ip7_cycle", firstIp, 22);
        check("timer_trap_cycle", firstTrap, 22);
        check("timer_trap_pulses", pulses, 1);
        check("timer_epc", sampledEpc, 32'h0040_0000 + 23 * 4);
        rd(5'd12, 0, 0);
        check("status_after_trap", sampledRdata, 32'h0000_8000);
        wr(5'd11, 32'h7FFF_FFFF, 0, 0);
        rd(5'd13, 0, 0);
        check("ip7_cleared", sampledRdata, 32'h0);

        // Stall holds the decision for rx interrupt
        step(0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 0, 0, 1);
        wr(5'd12, 32'h0000_0401, 0, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 5'd0, 32'h0, 32'h0, 1, 0, 1);
            if (sampledTrap) pulses++;
        end
        check("stall_no_trap", pulses, 0);
        step(0, 0, 0, 0, 5'd0, 32'h0, 32'h100, 1, 0, 1);
        check("unstall_trap", {31'h0, sampledTrap}, 32'h1);
        step(0, 0, 0, 0, 5'd0, 32'h0, 32'h200, 1, 0, 1);
        check("trap_one_cycle", {31'h0, sampledTrap}, 32'h0);
        check("rx_epc", sampledEpc, 32'h200);
        step(0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 1, 0, 1);
        rd(5'd12, 1, 0);
        check("eret_ie", sampledRdata, 32'h0000_0401);
        check("retrap", {31'h0, sampledTrap}, 32'h1);

        // Count wrap and Compare=0 match on the wrap
        step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 1);
        step(0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 0, 0, 1);
        wr(5'd12, 32'h0, 0, 0);
        wr(5'd11, 32'h0, 0, 0);
        wr(5'd9, 32'hFFFF_FFFE, 0, 0);
        rd(5'd9, 0, 0);
        check("wrap_fffe", sampledRdata, 32'hFFFF_FFFE);
        rd(5'd9, 0, 0);
        check("wrap_ffff", sampledRdata, 32'hFFFF_FFFF);
        rd(5'd9, 0, 0);
        check("wrap_zero", sampledRdata, 32'h0);
        rd(5'd13, 0, 0);
        check("wrap_ip7", sampledRdata, 32'h0000_8000);

        // Status write in the trap-decision cycle is discarded
        wr(5'd12, 32'h0000_0801, 0, 1);
        wr(5'd12, 32'h0000_0000, 0, 1);
        check("tx_trap", {31'h0, sampledTrap}, 32'h1);
        step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 1, 1);
        rd(5'd12, 0, 1);
        check("status_kept", sampledRdata, 32'h0000_0800);

        // Reset during the TRAP cycle
        step(0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 0, 1, 1);
        step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 1, 1);
        check("pre_reset_trap", {31'h0, sampledTrap}, 32'h1);
        step(0, 0, 0, 0, 5'd0, 32'h0, 32'hDEAD_0000, 0, 1, 0);
        check("reset_trap", {31'h0, sampledTrap}, 32'h0);
        check("reset_epc", sampledEpc, 32'h0);
        rd(5'd13, 0, 0);
        check("reset_cause", sampledRdata, 32'h0);
        rd(5'd12, 0, 0);
        check("reset_status", sampledRdata, 32'h0);
        rd(5'd11, 0, 0);
        check("reset_compare", sampledRdata, 32'h0);
        rd(5'd14, 0, 0);
        check("reset_epc_rd", sampledRdata, 32'h0);
        rd(5'd9, 0, 0);
        check("reset_count", sampledRdata, 32'd4);

        // Random traffic against the model
        rRx = 0; rTx = 0;
        for (int i = 0; i < 500; i++) begin
            logic w, r, e, s;
            logic [4:0] a;
            logic [31:0] d;
            int sel;
            if ($urandom_range(0, 4) == 0) rRx = ~rRx;
            if ($urandom_range(0, 4) == 0) rTx = ~rTx;
            s = ($urandom_range(0, 99) < 20);
            e = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 6);
            case (sel)
                0: a = 5'd9;  1: a = 5'd11; 2: a = 5'd12; 3: a = 5'd13;
                4: a = 5'd14; 5: a = 5'd7;  default: a = 5'd0;
            endcase
            w = ($urandom_range(0, 3) == 0) && (mMode != M_TRAP)
                && !(mMode == M_RUN && modelPending(rRx, rTx));
            d = $urandom;
            if ((a == 5'd9 || a == 5'd11) && $urandom_range(0, 1) == 1)
                d = mCount + $urandom_range(0, 30);
            step(w, r, e, s, a, d, $urandom, rRx, rTx, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
